fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage RISC-V core. It holds the program counter, selects the next PC from the sequential PC+4 or the execute-stage redirect, and registers the fetched word into the decode stage. It feeds the decode-stage fields `opD`, `funct3D` and `funct7b5D` to the pipeline controller, and the register specifiers to the register file and hazard unit. It obeys stall and flush commands from the hazard unit and optionally traps misaligned redirect targets.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the
//   five-stage RISC-V core. Holds the program counter, picks the next PC
//   (sequential PC+4 or the execute-stage redirect), and registers the
//   fetched word and its PC into the decode stage.
//
//   Build option: define FETCH_FAULT_EN to compile in the RUN/FAULT machine
//   that traps misaligned redirect targets. Without it, redirect targets
//   are silently word-aligned and FaultF/FaultPC read as zero.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   StallF, StallD      hazard unit: hold PCF / hold IF/ID
//   FlushD              hazard unit: bubble into IF/ID (beats StallD)
//   PCSrcE, PCTargetE   execute-stage redirect request and target
//   InstrF              instruction memory read data for PCF (same cycle)
//   PCF                 fetch address to instruction memory
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents
//   opD, funct3D, funct7b5D, Rs1D, Rs2D, RdD   slices of InstrD
//   FaultF, FaultPC     sticky misaligned-redirect fault and its target
//
// Control semantics (no valid/ready handshake here; the hazard unit drives
// level commands sampled on every rising edge):
//   PC:    redirect > StallF hold > PC+4   (fault state freezes PC)
//   IF/ID: rst/FlushD bubble > StallD hold > load   (fault state bubbles
//          every cycle unless StallD holds it)

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [6:0]  opD,
    output logic [2:0]  funct3D,
    output logic        funct7b5D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic        ValidD,
    output logic        FaultF,
    output logic [31:0] FaultPC
);

    logic [31:0] pcPlus4F;
    logic [31:0] pcNext;
    logic [31:0] redirectPc;
    logic        holdPc;      // freeze PCF regardless of redirect/stall
    logic        inFault;     // machine is parked in FAULT
    logic        loadBubble;

    assign pcPlus4F = PCF + 32'd4;   // wraps naturally at 2^32

`ifdef FETCH_FAULT_EN
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetchState_t;

    fetchState_t state;
    fetchState_t stateNext;
    logic        faultTrig;

    // Debug view of the machine state for hierarchical checkers.
    logic        faultStateDbg;
    assign faultStateDbg = (state == FAULT);

    assign faultTrig = (state == RUN) && PCSrcE && (PCTargetE[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: only reset leaves FAULT
    always_comb begin
        stateNext = state;
        unique case (state)
            RUN:     if (faultTrig) stateNext = FAULT;
            FAULT:   stateNext = FAULT;
            default: stateNext = RUN;
        endcase
    end

    // Output logic: the offending cycle already holds PC so the bad
    // target is never loaded.
    always_comb begin
        inFault = (state == FAULT);
        holdPc  = inFault | faultTrig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            FaultF  <= 1'b0;
            FaultPC <= 32'h0;
        end else if (faultTrig) begin
            FaultF  <= 1'b1;
            FaultPC <= PCTargetE;
        end
    end

    assign redirectPc = PCTargetE;
`else
    // Low target bits are dropped by the silent alignment below.
    logic unusedTargetLsbs;
    assign unusedTargetLsbs = ^PCTargetE[1:0];

    assign inFault    = 1'b0;
    assign holdPc     = 1'b0;
    assign redirectPc = {PCTargetE[31:2], 2'b00};
    assign FaultF     = 1'b0;
    assign FaultPC    = 32'h0;
`endif

    // Next PC: a redirect overrides StallF
    always_comb begin
        pcNext = PCF;
        if (holdPc) begin
            pcNext = PCF;
        end else if (PCSrcE) begin
            pcNext = redirectPc;
        end else if (!StallF) begin
            pcNext = pcPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pcNext;
        end
    end

    // IF/ID register: flush beats stall; FAULT keeps inserting bubbles
    assign loadBubble = FlushD | (inFault & ~StallD);

    always_ff @(posedge clk) begin
        if (rst || loadBubble) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // Decode fields are plain slices; a bubble decodes as addi x0,x0,0
    assign opD       = InstrD[6:0];
    assign RdD       = InstrD[11:7];
    assign funct3D   = InstrD[14:12];
    assign Rs1D      = InstrD[19:15];
    assign Rs2D      = InstrD[24:20];
    assign funct7b5D = InstrD[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed test-plan sequence followed by
// randomized hazard/redirect traffic, checked against a behavioural model
// through an expected-value queue.
module tb_fetch_stage;

`ifdef FETCH_FAULT_EN
    localparam bit FaultEn = 1'b1;
`else
    localparam bit FaultEn = 1'b0;
`endif

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam int W = 162;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, FaultPC;
    logic [6:0]  opD;
    logic [2:0]  funct3D;
    logic        funct7b5D, ValidD, FaultF;
    logic [4:0]  Rs1D, Rs2D, RdD;

    always #5 clk = ~clk;

    // Instruction memory: a fixed scrambling of the address, or a forced word
    bit          useOverride = 1'b1;
    logic [31:0] overrideVal = 32'h0050_0093;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign InstrF = useOverride ? overrideVal : memWord(PCF);

    fetch_stage #(.RESET_PC(ResetPc), .NOP_INSTR(NopInstr)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .opD(opD), .funct3D(funct3D),
        .funct7b5D(funct7b5D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidD(ValidD), .FaultF(FaultF), .FaultPC(FaultPC)
    );

    // ---------------- reference model ----------------
    logic [31:0] mPc, mInstrD, mPcD, mPcPlus4D, mFaultPc;
    logic        mValidD, mFault;

    logic [W-1:0] exp_q[$];
    int totalCnt = 0;
    int badCnt = 0;

    // Apply one cycle of commands on the falling edge, advance the model
    // across the following rising edge and queue what the DUT must show.
    task automatic drive(input bit r, input bit sf, input bit sd,
                         input bit fd, input bit ps, input logic [31:0] tgt,
                         input bit ovr);
        logic [31:0] fetched;
        bit          trap;
        @(negedge clk);
        rst = r; StallF = sf; StallD = sd; FlushD = fd;
        PCSrcE = ps; PCTargetE = tgt; useOverride = ovr;

        if (r) begin
            mPc = ResetPc; mInstrD = NopInstr; mPcD = 0; mPcPlus4D = 0;
            mValidD = 0; mFault = 0; mFaultPc = 0;
        end else begin
            fetched = ovr ? overrideVal : memWord(mPc);
            trap = FaultEn && !mFault && ps && (tgt % 4 != 0);
            // decode register
            if (fd || (mFault && !sd)) begin
                mInstrD = NopInstr; mPcD = 0; mPcPlus4D = 0; mValidD = 0;
            end else if (!sd) begin
                mInstrD = fetched; mPcD = mPc; mPcPlus4D = mPc + 4; mValidD = 1;
            end
            // program counter
            if (mFault || trap) begin
                mPc = mPc;
            end else if (ps) begin
                mPc = FaultEn ? tgt : (tgt / 4) * 4;
            end else if (!sf) begin
                mPc = mPc + 4;
            end
            if (trap) begin
                mFault = 1; mFaultPc = tgt;
            end
        end
        exp_q.push_back({mPc, mInstrD, mPcD, mPcPlus4D, mValidD, mFault, mFaultPc});
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        totalCnt++;
        if (act !== want) begin
            badCnt++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    initial begin
        logic [W-1:0] e;
        logic [31:0] ePc, eInstr, ePcD, ePc4, eFpc;
        logic eValid, eFault;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                {ePc, eInstr, ePcD, ePc4, eValid, eFault, eFpc} = e;
                check("PCF", PCF, ePc);
                check("InstrD", InstrD, eInstr);
                check("PCD", PCD, ePcD);
                check("PCPlus4D", PCPlus4D, ePc4);
                check("ValidD", {31'b0, ValidD}, {31'b0, eValid});
                check("FaultF", {31'b0, FaultF}, {31'b0, eFault});
                check("FaultPC", FaultPC, eFpc);
                check("opD", {25'b0, opD}, {25'b0, eInstr[6:0]});
                check("RdD", {27'b0, RdD}, {27'b0, eInstr[11:7]});
                check("funct3D", {29'b0, funct3D}, {29'b0, eInstr[14:12]});
                check("Rs1D", {27'b0, Rs1D}, {27'b0, eInstr[19:15]});
                check("Rs2D", {27'b0, Rs2D}, {27'b0, eInstr[24:20]});
                check("funct7b5D", {31'b0, funct7b5D}, {31'b0, eInstr[30]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          r, sf, sd, fd, ps;
        logic [31:0] tgt;
        int          pick;

        // reset then free run with a forced first word
        drive(1, 0, 0, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        // load-use stall at PCF=8 for two cycles, then resume
        drive(0, 1, 1, 0, 0, 32'h0, 0);
        drive(0, 1, 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 32'h0, 0);
        // redirect with flush, redirect overrides StallF
        drive(0, 1, 0, 1, 1, 32'h40, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        // flush wins over stall
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        // misaligned redirect from PCF=0x10
        drive(0, 0, 0, 1, 1, 32'h10, 0);
        drive(0, 0, 0, 1, 1, 32'h42, 0);
        for (int i = 0; i < 5; i++) drive(0, i[0], 0, i[1], 1, 32'h80 + 32'(i * 4), 0);
        drive(0, 0, 1, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 4) == 0) begin
                sf = 1; sd = 1;
            end else begin
                sf = ($urandom_range(0, 9) == 0);
                sd = ($urandom_range(0, 9) == 0);
            end
            ps = ($urandom_range(0, 5) == 0);
            fd = ps ? 1'b1 : ($urandom_range(0, 11) == 0);
            pick = $urandom_range(0, 3);
            case (pick)
                0: tgt = {$urandom_range(0, 32'h3FFF_FFFF) , 2'b00} ;
                1: tgt = 32'hFFFF_FFF8;
                2: tgt = $urandom;
                default: tgt = 32'($urandom_range(0, 255)) << 2;
            endcase
            drive(r, sf, sd, fd, ps, tgt, 0);
        end

        // drain with a bounded wait
        @(negedge clk);
        rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            badCnt++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
